// File: rtl/ysyx_23060203_redirect_ctrl_if.sv
// Redirect/flush scheduler bus: WBU/EXU requests, IFU status, ICache invalidate handshake.
// slave = scheduler side, master = surrounding pipeline side.
interface ysyx_23060203_redirect_ctrl_if #(
  parameter int PC_W = 32
);
  logic            cs_flush;
  logic [PC_W-1:0] cs_dnpc;
  logic            fencei;
  logic            br_valid;
  logic [PC_W-1:0] br_dnpc;
  logic            ifu_idle;
  logic            inv_ready;
  logic            inv_valid;
  logic            flush_front;
  logic            flush_back;
  logic            ifu_stall;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;

  modport slave (
    input  cs_flush, cs_dnpc, fencei, br_valid, br_dnpc, ifu_idle, inv_ready,
    output inv_valid, flush_front, flush_back, ifu_stall, redirect_valid, redirect_pc
  );

  modport master (
    output cs_flush, cs_dnpc, fencei, br_valid, br_dnpc, ifu_idle, inv_ready,
    input  inv_valid, flush_front, flush_back, ifu_stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_23060203_redirect_ctrl.sv
// Pipeline redirect/flush scheduler: arbitrates WBU flushes against EXU branches and sequences fence.i.
// Optional performance counters enabled by defining YSYX_23060203_REDIRECT_PERF_EN.
//
// state  | meaning
// IDLE   | accept cs_flush / br_valid requests
// DRAIN  | fence.i: IFU stalled, waiting for in-flight fetch to finish
// INV    | fence.i: ICache invalidate requested, waiting for inv_ready
// RESUME | fence.i: issue redirect to latched target
module ysyx_23060203_redirect_ctrl #(
  parameter int PC_W         = 32,
  parameter bit FENCEI_DRAIN = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset,
  ysyx_23060203_redirect_ctrl_if.slave  bus
`ifdef YSYX_23060203_REDIRECT_PERF_EN
  ,
  output logic [31:0]                   perf_flush_cnt,
  output logic [31:0]                   perf_br_cnt,
  output logic [31:0]                   perf_fencei_cnt,
  output logic [31:0]                   perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_INV    = 2'd2,
    S_RESUME = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [PC_W-1:0] target, target_nx;
  logic            inv_valid_nx;
  logic            flush_front_nx;
  logic            flush_back_nx;
  logic            ifu_stall_nx;
  logic            redirect_valid_nx;
  logic [PC_W-1:0] redirect_pc_nx;
  logic            acc_flush;
  logic            acc_br;
  logic            acc_fencei;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      target             <= '0;
      bus.inv_valid      <= 1'b0;
      bus.flush_front    <= 1'b0;
      bus.flush_back     <= 1'b0;
      bus.ifu_stall      <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
    end else begin
      state              <= state_nx;
      target             <= target_nx;
      bus.inv_valid      <= inv_valid_nx;
      bus.flush_front    <= flush_front_nx;
      bus.flush_back     <= flush_back_nx;
      bus.ifu_stall      <= ifu_stall_nx;
      bus.redirect_valid <= redirect_valid_nx;
      bus.redirect_pc    <= redirect_pc_nx;
    end
  end

  // Outputs are registered, so every output is derived from the state being entered.
  always_comb begin
    state_nx          = state;
    target_nx         = target;
    flush_front_nx    = 1'b0;
    flush_back_nx     = 1'b0;
    redirect_valid_nx = 1'b0;
    redirect_pc_nx    = bus.redirect_pc;
    acc_flush         = 1'b0;
    acc_br            = 1'b0;
    acc_fencei        = 1'b0;

    case (state)
      S_IDLE: begin
        // cs_flush belongs to an older instruction than any branch, so it wins.
        if (bus.cs_flush) begin
          acc_flush      = 1'b1;
          flush_front_nx = 1'b1;
          flush_back_nx  = 1'b1;
          if (bus.fencei) begin
            acc_fencei = 1'b1;
            target_nx  = bus.cs_dnpc;
            state_nx   = FENCEI_DRAIN ? S_DRAIN : S_INV;
          end else begin
            redirect_valid_nx = 1'b1;
            redirect_pc_nx    = bus.cs_dnpc;
          end
        end else if (bus.br_valid) begin
          acc_br            = 1'b1;
          flush_front_nx    = 1'b1;
          redirect_valid_nx = 1'b1;
          redirect_pc_nx    = bus.br_dnpc;
        end
      end
      S_DRAIN: begin
        if (bus.ifu_idle) state_nx = S_INV;
      end
      S_INV: begin
        if (bus.inv_valid && bus.inv_ready) state_nx = S_RESUME;
      end
      S_RESUME: begin
        redirect_valid_nx = 1'b1;
        redirect_pc_nx    = target;
        state_nx          = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    ifu_stall_nx = (state_nx != S_IDLE);
    inv_valid_nx = (state_nx == S_INV);
  end

`ifdef YSYX_23060203_REDIRECT_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_flush_cnt  <= '0;
      perf_br_cnt     <= '0;
      perf_fencei_cnt <= '0;
      perf_stall_cnt  <= '0;
    end else begin
      if (acc_flush)     perf_flush_cnt  <= perf_flush_cnt + 32'd1;
      if (acc_br)        perf_br_cnt     <= perf_br_cnt + 32'd1;
      if (acc_fencei)    perf_fencei_cnt <= perf_fencei_cnt + 32'd1;
      if (bus.ifu_stall) perf_stall_cnt  <= perf_stall_cnt + 32'd1;
    end
  end
`else
  logic unused_acc;
  assign unused_acc = acc_flush ^ acc_br ^ acc_fencei;
`endif

endmodule
